// File: rtl/kyber_stream_mux.sv
// kyber_stream_mux: buffers the Kyber_top server (public key) and client
// (ciphertext) word streams in two show-ahead FIFOs and merges them onto one
// valid/ready stream, one whole packet per source, with last/id framing.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, k            run start pulse and Kyber parameter latched on it
//   valid_server/dout_server, valid_client/dout_client  unthrottled inputs
//   m_data/m_valid/m_ready/m_last/m_id                  merged output stream
//   ovf_server/ovf_client/err_k                         sticky status flags
module kyber_stream_mux #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  k,
  input  logic        valid_server,
  input  logic [31:0] dout_server,
  input  logic        valid_client,
  input  logic [31:0] dout_client,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        m_id,
  output logic        ovf_server,
  output logic        ovf_client,
  output logic        err_k
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SRV  = 2'd1;
  localparam logic [1:0] ST_CLI  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state_q, state_nxt;
  logic [31:0]   mem_s [DEPTH];
  logic [31:0]   mem_c [DEPTH];
  logic [AW-1:0] wp_s, rp_s, wp_c, rp_c;
  logic [CW-1:0] cnt_s, cnt_c;
  logic [2:0]    k_q;
  logic          sent_s, sent_c;
  logic [LW-1:0] wcnt;   // handshakes in the current packet
  logic [LW-1:0] icnt;   // words moved into the output register this packet

  logic [LW-1:0] pk_len, ct_len, cur_len;
  logic          in_pkt, src_empty, hs, load, last_hs;
  logic          full_s, full_c, rd_s, rd_c, wr_s, wr_c;
  logic          ovf_s_set, ovf_c_set;
  logic          k_legal;

  // Packet lengths, FIFO strobes and next state
  always_comb begin
    pk_len    = LW'(392);
    ct_len    = LW'(392);
    case (k_q)
      3'd2: begin pk_len = LW'(200); ct_len = LW'(192); end
      3'd3: begin pk_len = LW'(296); ct_len = LW'(272); end
      default: ;
    endcase
    in_pkt    = (state_q == ST_SRV) || (state_q == ST_CLI);
    cur_len   = (state_q == ST_CLI) ? ct_len : pk_len;
    src_empty = (state_q == ST_CLI) ? (cnt_c == '0) : (cnt_s == '0);
    hs        = m_valid & m_ready;
    // Refill the output register when it is free or being drained this cycle
    load      = in_pkt && (!m_valid || hs) && !src_empty && (icnt < cur_len);
    rd_s      = load && (state_q == ST_SRV);
    rd_c      = load && (state_q == ST_CLI);
    full_s    = (cnt_s == CW'(DEPTH));
    full_c    = (cnt_c == CW'(DEPTH));
    // A read in the same cycle frees the slot a full FIFO needs for the write
    wr_s      = valid_server && !err_k && (!full_s || rd_s);
    wr_c      = valid_client && !err_k && (!full_c || rd_c);
    ovf_s_set = valid_server && !err_k && full_s && !rd_s;
    ovf_c_set = valid_client && !err_k && full_c && !rd_c;
    last_hs   = in_pkt && hs && (wcnt == cur_len - LW'(1));
    k_legal   = (k == 3'd2) || (k == 3'd3) || (k == 3'd4);

    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_s != '0 && !sent_s)      state_nxt = ST_SRV;
        else if (cnt_c != '0 && !sent_c) state_nxt = ST_CLI;
      end
      ST_SRV, ST_CLI: if (last_hs) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FIFO storage (pointers reset separately, contents need no reset)
  always_ff @(posedge clk) begin
    if (wr_s) mem_s[wp_s] <= dout_server;
    if (wr_c) mem_c[wp_c] <= dout_client;
  end

  // State, FIFO pointers, output register and flags
  always_ff @(posedge clk) begin
    if (rst || start) begin
      state_q    <= ST_IDLE;
      wp_s       <= '0;
      rp_s       <= '0;
      cnt_s      <= '0;
      wp_c       <= '0;
      rp_c       <= '0;
      cnt_c      <= '0;
      sent_s     <= 1'b0;
      sent_c     <= 1'b0;
      wcnt       <= '0;
      icnt       <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_id       <= 1'b0;
      ovf_server <= 1'b0;
      ovf_client <= 1'b0;
      k_q        <= rst ? 3'd4 : k;
      err_k      <= rst ? 1'b0 : !k_legal;
    end else begin
      state_q <= state_nxt;

      if (wr_s) wp_s <= wp_s + AW'(1);
      if (rd_s) rp_s <= rp_s + AW'(1);
      cnt_s <= cnt_s + CW'(wr_s) - CW'(rd_s);
      if (wr_c) wp_c <= wp_c + AW'(1);
      if (rd_c) rp_c <= rp_c + AW'(1);
      cnt_c <= cnt_c + CW'(wr_c) - CW'(rd_c);

      if (load) begin
        m_data  <= (state_q == ST_CLI) ? mem_c[rp_c] : mem_s[rp_s];
        m_valid <= 1'b1;
        m_last  <= (icnt == cur_len - LW'(1));
        m_id    <= (state_q == ST_CLI);
        icnt    <= icnt + LW'(1);
      end else if (hs) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (last_hs) begin
        wcnt <= '0;
        icnt <= '0;
        if (state_q == ST_SRV) sent_s <= 1'b1;
        else                   sent_c <= 1'b1;
      end else if (hs) begin
        wcnt <= wcnt + LW'(1);
      end

      ovf_server <= ovf_server | ovf_s_set;
      ovf_client <= ovf_client | ovf_c_set;
    end
  end

endmodule

// File: tb/tb_kyber_stream_mux.sv
// tb_kyber_stream_mux: randomized stimulus with a per-source expected-word
// scoreboard; a negedge monitor pops and compares on every output handshake.
module tb_kyber_stream_mux;

  localparam int unsigned DEPTH = 64;
  localparam int          LIM   = DEPTH - 4;

  logic        clk, rst, start;
  logic [2:0]  k;
  logic        valid_server, valid_client;
  logic [31:0] dout_server, dout_client;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_last, m_id;
  logic        ovf_server, ovf_client, err_k;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_s[$];
  logic [32:0] exp_c[$];
  int sent_cnt [2];
  int emit_cnt [2];
  int cur_k = 4;
  int ready_mode = 0;  // 0: always 1, 1: toggle, 2: random, 3: always 0
  int rdy_pct = 100;
  bit tog = 1'b0;

  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last, prev_id;
  bit          pkt_open = 1'b0;
  logic        pkt_id = 1'b0;

  kyber_stream_mux #(.DEPTH(DEPTH), .AW(6)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k),
    .valid_server(valid_server), .dout_server(dout_server),
    .valid_client(valid_client), .dout_client(dout_client),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_id(m_id),
    .ovf_server(ovf_server), .ovf_client(ovf_client), .err_k(err_k)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pk_len(int kk);
    return 96 * kk + 8;
  endfunction

  function automatic int ct_len(int kk);
    case (kk)
      2: return 192;
      3: return 272;
      default: return 392;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (rst || start) begin
      prev_stall  = 1'b0;
      pkt_open    = 1'b0;
      emit_cnt[0] = 0;
      emit_cnt[1] = 0;
    end else begin
      if (prev_stall) begin
        check("stall_data", m_data, prev_data);
        check("stall_ctl", 32'({m_valid, m_last, m_id}), 32'({1'b1, prev_last, prev_id}));
      end
      if (m_valid && ((m_id == 1'b0 && exp_s.size() == 0) ||
                      (m_id == 1'b1 && exp_c.size() == 0)))
        check("spurious_valid", 32'(m_valid), 32'd0);
      else if (m_valid && m_ready) begin
        logic [32:0] e;
        if (pkt_open) check("interleave_id", 32'(m_id), 32'(pkt_id));
        e = (m_id == 1'b0) ? exp_s.pop_front() : exp_c.pop_front();
        check(m_id ? "cli_data" : "srv_data", m_data, e[31:0]);
        check(m_id ? "cli_last" : "srv_last", 32'(m_last), 32'(e[32]));
        emit_cnt[m_id]++;
        pkt_open = !m_last;
        pkt_id   = m_id;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_id    = m_id;
    end
  end

  // One clock step: drive new inputs #1 after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
    valid_server = 1'b0;
    valid_client = 1'b0;
    start        = 1'b0;
    tog          = ~tog;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: m_ready = tog;
      2: m_ready = (($urandom % 100) < 32'(rdy_pct));
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic flush_model();
    exp_s.delete();
    exp_c.delete();
    sent_cnt[0] = 0;
    sent_cnt[1] = 0;
  endtask

  task automatic do_start(int kk);
    cyc();
    start = 1'b1;
    k     = 3'(kk);
    cur_k = kk;
    cyc();
    flush_model();
  endtask

  task automatic do_rst();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    flush_model();
  endtask

  task automatic push_exp(int ch, int idx, logic [31:0] d);
    int len;
    len = (ch == 0) ? pk_len(cur_k) : ct_len(cur_k);
    if (ch == 0) exp_s.push_back({idx == len - 1, d});
    else         exp_c.push_back({idx == len - 1, d});
    sent_cnt[ch]++;
  endtask

  // Drive word indices [from,to) per source; only indices below keep are
  // expected at the output. throttle bounds words in flight per source.
  task automatic run_stream(int s_from, int s_to, int c_from, int c_to,
                            int s_keep, int c_keep, int ps, int pc,
                            bit throttle, bit s_first);
    int si = s_from;
    int ci = c_from;
    int budget = 0;
    logic [31:0] d;
    while ((si < s_to || ci < c_to) && budget < 20000) begin
      cyc();
      if (si < s_to && ($urandom % 100) < 32'(ps) &&
          (!throttle || sent_cnt[0] - emit_cnt[0] < LIM)) begin
        d = $urandom;
        valid_server = 1'b1;
        dout_server  = d;
        if (si < s_keep) push_exp(0, si, d);
        si++;
      end
      if (ci < c_to && (!s_first || si >= s_to) && ($urandom % 100) < 32'(pc) &&
          (!throttle || sent_cnt[1] - emit_cnt[1] < LIM)) begin
        d = $urandom;
        valid_client = 1'b1;
        dout_client  = d;
        if (ci < c_keep) push_exp(1, ci, d);
        ci++;
      end
      budget++;
    end
    cyc();
    if (budget >= 20000) begin
      checks++;
      errors++;
      $display("FAIL stream_budget: sent %0d/%0d server %0d/%0d client", si, s_to, ci, c_to);
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while ((exp_s.size() != 0 || exp_c.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (exp_s.size() != 0 || exp_c.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d server and %0d client words still expected",
               exp_s.size(), exp_c.size());
    end
    repeat (4) cyc();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k = 3'd4; m_ready = 1'b0;
    valid_server = 1'b0; valid_client = 1'b0;
    dout_server = '0; dout_client = '0;
    sent_cnt[0] = 0; sent_cnt[1] = 0;
    ready_mode = 3;
    cyc();
    cyc();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_id", 32'(m_id), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_flags", 32'({ovf_server, ovf_client, err_k}), 32'd0);
    rst = 1'b0;

    // k=4 server packet, back-to-back, always ready
    ready_mode = 0;
    do_start(4);
    run_stream(0, 392, 0, 0, 392, 0, 100, 0, 1'b0, 1'b0);
    wait_drain(2000);
    check("t1_ovf_server", 32'(ovf_server), 32'd0);

    // k=2 server then client, ready toggling
    ready_mode = 1;
    do_start(2);
    run_stream(0, 200, 0, 192, 200, 192, 100, 100, 1'b1, 1'b1);
    wait_drain(3000);
    check("t2_ovf", 32'({ovf_server, ovf_client}), 32'd0);

    // k=3 both strobing every cycle: client overflows while server drains
    ready_mode = 0;
    do_start(3);
    run_stream(0, 296, 0, 296, 296, 64, 100, 100, 1'b0, 1'b0);
    check("t3_ovf_client", 32'(ovf_client), 32'd1);
    check("t3_ovf_server", 32'(ovf_server), 32'd0);
    run_stream(0, 0, 64, 272, 0, 272, 0, 100, 1'b1, 1'b0);
    wait_drain(3000);

    // illegal k: inputs ignored, then a legal start clears err_k
    do_start(5);
    run_stream(0, 50, 0, 50, 0, 0, 100, 100, 1'b0, 1'b0);
    check("t4_err_k", 32'(err_k), 32'd1);
    check("t4_m_valid", 32'(m_valid), 32'd0);
    do_start(2);
    check("t4_err_k_clr", 32'(err_k), 32'd0);

    // reset mid-packet, then a fresh full packet
    do_start(4);
    run_stream(0, 100, 0, 0, 100, 0, 100, 0, 1'b0, 1'b0);
    do_rst();
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_m_last", 32'(m_last), 32'd0);
    check("t5_flags", 32'({ovf_server, ovf_client, err_k}), 32'd0);
    do_start(4);
    run_stream(0, 392, 0, 0, 392, 0, 100, 0, 1'b0, 1'b0);
    wait_drain(2000);

    // fill server FIFO while stalled, then read and write at the same edge
    ready_mode = 3;
    do_start(2);
    run_stream(0, 65, 0, 0, 200, 0, 100, 0, 1'b0, 1'b0);
    ready_mode = 0;
    run_stream(65, 85, 0, 0, 200, 0, 100, 0, 1'b0, 1'b0);
    check("t6_ovf_server_full", 32'(ovf_server), 32'd0);
    run_stream(85, 200, 0, 0, 200, 0, 100, 0, 1'b1, 1'b0);
    wait_drain(2000);
    check("t6_ovf_server", 32'(ovf_server), 32'd0);

    // randomized k, strobe densities and backpressure
    for (int it = 0; it < 3; it++) begin
      int kk;
      kk = 2 + int'($urandom % 3);
      ready_mode = 2;
      rdy_pct = 40 + int'($urandom % 60);
      do_start(kk);
      run_stream(0, pk_len(kk), 0, ct_len(kk), pk_len(kk), ct_len(kk),
                 20 + int'($urandom % 80), 20 + int'($urandom % 80), 1'b1, 1'b0);
      wait_drain(20000);
      check("rnd_ovf", 32'({ovf_server, ovf_client}), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kyber_stream_mux.md
Name: kyber_stream_mux

Overview:
- Downstream stage of Kyber_top. Consumes its two unthrottled 32-bit output streams: valid_server/dout_server carries the public key; valid_client/dout_client carries the ciphertext.
- Buffers each stream in its own FIFO.
- Merges both onto a single valid/ready output stream with packet framing (last flag, source id), for a DMA or host interface.
- Sizes each packet from the Kyber security parameter k.

Parameters:
- DEPTH, 64, words per input FIFO; power of two, minimum 4.
- AW, 6, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse, same pulse as Kyber_top start. Latches k, clears FIFOs, counters and flags.
- k  in  3  Kyber parameter; legal values are 2, 3, 4.
- valid_server  in  1  server word strobe.
- dout_server  in  32  server (public-key) word.
- valid_client  in  1  client word strobe.
- dout_client  in  32  client (ciphertext) word.
- m_data  out  32  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_last  out  1  final word of the current packet.
- m_id  out  1  packet source: 0 = server, 1 = client.
- ovf_server  out  1  sticky, server FIFO overflowed.
- ovf_client  out  1  sticky, client FIFO overflowed.
- err_k  out  1  sticky, latched k was illegal.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFOs empty, state IDLE.
  - m_valid=0, m_last=0, m_id=0, m_data=0.
  - ovf_server=0, ovf_client=0, err_k=0.
  - Latched k = 4.
- Reset is allowed at any time, including mid-packet; partial packets are discarded.
- start:
  - Same cycle effect as reset, except k is latched from the port.
  - err_k=1 if k is not 2, 3 or 4; otherwise err_k=0.
  - A start pulse coinciding with valid_server or valid_client discards that word.
  - rst has priority over start.
- Packet lengths, in 32-bit words, from latched k:
  - Server: PK_LEN = 96*k + 8, giving 200 / 296 / 392 for k = 2 / 3 / 4.
  - Client: CT_LEN = 192 / 272 / 392 for k = 2 / 3 / 4.
  - Both are fixed at start.
- While err_k=1, input strobes are ignored: nothing is written and m_valid stays 0.
- Input FIFOs:
  - A word is written on the edge where its strobe=1 and the FIFO is not full. There is no input backpressure.
  - Strobe=1 while full and no read that cycle: word dropped, that channel's ovf flag set and held until rst/start.
  - Full with a read and a write in the same cycle: write accepted, count unchanged.
  - FIFOs are show-ahead; pointers wrap modulo DEPTH.
  - A full flag is kept so that count=DEPTH is distinct from empty.
- Latency: a word written at edge t is visible on m_data after edge t+1 at the earliest (one registered output stage).
- Output state machine:
  - IDLE:
    - Server FIFO non-empty and server packet not yet sent since start -> SRV.
    - Otherwise client FIFO non-empty and client packet not yet sent -> CLI.
    - Server has priority when both are pending.
  - SRV / CLI:
    - m_id = 0 / 1.
    - m_valid=1 whenever the output register holds a word.
    - Word counter cnt counts handshakes (m_valid & m_ready) from 0.
    - m_last=1 exactly when cnt = LEN-1.
    - On the handshake of the last word -> DONE_CHK and set that channel's sent flag.
    - An empty FIFO mid-packet deasserts m_valid without leaving the state.
  - DONE_CHK: one cycle, then IDLE.
  - Once both packets are sent, stay in IDLE. Further input words are stored but never emitted until start.
- Output stability: while m_valid=1 and m_ready=0, m_data, m_last and m_id hold stable.
- A packet never interleaves with the other channel's words. Switching happens only at packet boundaries.
- Throughput: one word per cycle sustained while m_ready=1 and the source FIFO stays non-empty.

Test Plan:
- k=4, start, 392 server words on consecutive cycles, m_ready=1 -> 392 output words with m_id=0, in order, m_last only on word 392, ovf_server stays 0.
- k=2, 200 server words then 192 client words, m_ready toggling 1/0 every cycle -> server packet of 200 words then client packet of 192 words, m_data stable while stalled, m_last on words 200 and 192.
- k=3, server and client streams both strobing every cycle, DEPTH=64, m_ready=1 -> full 296-word server packet, then client packet. ovf_client=1 once client words exceed 64 buffered; first 64 client words emitted intact.
- k=5, start, strobes active -> err_k=1, m_valid never asserts; a new start with k=2 clears err_k.
- rst asserted after 100 of 392 server words (k=4) -> next cycle m_valid=0, all flags 0. After start and a fresh stream, the packet begins at word 0.
- Write and read at the same edge with server FIFO full -> occupancy unchanged, ovf_server stays 0.
